// File: rtl/apb_regfile_pkg.sv
// Shared definitions for the APB-to-regfile bridge: FSM encoding, APB response codes
// and a small helper used to size the latency counter.
package apb_regfile_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_WAIT   = ST_WAIT,
    S_DONE   = ST_DONE,
    S_ERR    = ST_ERR
  } state_e;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  function automatic int lat_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apb_addr_chk.sv
// Address legality check for a single regfile window: word aligned and within 0..addr_hi.
module apb_addr_chk
  import apb_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [ADDR_WIDTH-1:0] addr_hi,
  output logic                  addr_err
);

  assign addr_err = (paddr[1:0] != 2'b00) || (paddr > addr_hi);

endmodule

// File: rtl/apb_regfile_bridge.sv
// APB3 slave that turns each APB transfer into one regfile bus strobe, stretching the
// access with wait states to cover the regfile read/write latency.
module apb_regfile_bridge
  import apb_regfile_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    WDATA_WIDTH = 32,
  parameter int                    RDATA_WIDTH = 32,
  parameter int                    RD_LAT      = 1,
  parameter int                    WR_LAT      = 1,
  parameter logic [ADDR_WIDTH-1:0] ADDR_HI     = 'h4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [ADDR_WIDTH-1:0]  paddr,
  input  logic [WDATA_WIDTH-1:0] pwdata,
  output logic [RDATA_WIDTH-1:0] prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic                   reg_en,
  output logic                   reg_we,
  output logic [ADDR_WIDTH-1:0]  reg_addr,
  output logic [WDATA_WIDTH-1:0] reg_wdata,
  input  logic [RDATA_WIDTH-1:0] reg_rdata
);

  localparam int CW = $clog2(lat_max(RD_LAT, WR_LAT) + 1);

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   write_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [WDATA_WIDTH-1:0] wdata_q;
  logic [RDATA_WIDTH-1:0] prdata_q;
  logic                   pready_q;
  logic                   pslverr_q;
  logic                   reg_en_q;
  logic                   reg_we_q;
  logic                   addr_err;
  logic [CW-1:0]          lat_d;

  apb_addr_chk #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_chk (
    .paddr   (paddr),
    .addr_hi (ADDR_HI),
    .addr_err(addr_err)
  );

  assign lat_d = write_q ? CW'(WR_LAT) : CW'(RD_LAT);

  // Handshake: a transfer starts on a setup phase (psel & ~penable) seen in IDLE and ends
  // on a single-cycle pready; psel must stay high until then, otherwise the transfer is
  // dropped without a response. reg_en is a single-cycle strobe, reg_we is qualified by it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      reg_en_q  <= 1'b0;
      reg_we_q  <= 1'b0;
    end else begin
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      reg_en_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (psel && !penable) begin
            addr_q  <= paddr;
            wdata_q <= pwdata;
            write_q <= pwrite;
            if (addr_err) begin
              state_q   <= S_ERR;
              pready_q  <= 1'b1;
              pslverr_q <= RESP_SLVERR;
            end else begin
              state_q  <= S_ACCESS;
              reg_en_q <= 1'b1;
              reg_we_q <= pwrite;
            end
          end
        end
        S_ACCESS: begin
          if (!psel) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= lat_d;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (!psel) begin
            state_q <= S_IDLE;
          end else if (cnt_q == CW'(1)) begin
            state_q   <= S_DONE;
            pready_q  <= 1'b1;
            pslverr_q <= RESP_OKAY;
            if (!write_q) prdata_q <= reg_rdata;
          end
        end
        S_DONE, S_ERR: state_q <= S_IDLE;
        default:       state_q <= S_IDLE;
      endcase
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign reg_en    = reg_en_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;

endmodule

// File: tb/tb_apb_regfile_bridge.sv
// Bench for apb_regfile_bridge: two bridges with different latencies, each in front of a
// behavioural regfile, driven by directed APB sequences and random transfers.
module tb_apb_regfile_bridge;

  localparam int          RD_LAT0 = 1;
  localparam int          WR_LAT0 = 1;
  localparam int          RD_LAT1 = 3;
  localparam int          WR_LAT1 = 2;
  localparam logic [31:0] ADDR_HI = 32'h4;

  // clock/reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  int          sel = 0;

  logic        psel_v     [2];
  logic [31:0] prdata_v   [2];
  logic        pready_v   [2];
  logic        pslverr_v  [2];
  logic        reg_en_v   [2];
  logic        reg_we_v   [2];
  logic [31:0] reg_addr_v [2];
  logic [31:0] reg_wdata_v[2];
  logic [31:0] reg_rdata_v[2];

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem[2][2];

  assign psel_v[0] = psel && (sel == 0);
  assign psel_v[1] = psel && (sel == 1);

  apb_regfile_bridge #(
    .ADDR_WIDTH(32), .WDATA_WIDTH(32), .RDATA_WIDTH(32),
    .RD_LAT(RD_LAT0), .WR_LAT(WR_LAT0), .ADDR_HI(ADDR_HI)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
    .pslverr(pslverr_v[0]), .reg_en(reg_en_v[0]), .reg_we(reg_we_v[0]),
    .reg_addr(reg_addr_v[0]), .reg_wdata(reg_wdata_v[0]), .reg_rdata(reg_rdata_v[0])
  );

  apb_regfile_bridge #(
    .ADDR_WIDTH(32), .WDATA_WIDTH(32), .RDATA_WIDTH(32),
    .RD_LAT(RD_LAT1), .WR_LAT(WR_LAT1), .ADDR_HI(ADDR_HI)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
    .pslverr(pslverr_v[1]), .reg_en(reg_en_v[1]), .reg_we(reg_we_v[1]),
    .reg_addr(reg_addr_v[1]), .reg_wdata(reg_wdata_v[1]), .reg_rdata(reg_rdata_v[1])
  );

  // Behavioural regfiles: writes land on the strobe; read data appears RD_LAT cycles
  // after the strobe and is junk while the read is still in flight.
  logic [31:0] mem   [2][8];
  logic [31:0] rd_val[2];
  int          rd_cnt[2];

  initial begin
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 8; k++) mem[g][k] = '0;
      rd_cnt[g] = 0;
      rd_val[g] = '0;
      reg_rdata_v[g] = 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reg_en_v[g] && reg_we_v[g]) mem[g][reg_addr_v[g][4:2]] <= reg_wdata_v[g];
      if (reg_en_v[g] && !reg_we_v[g]) begin
        if ((g == 0 ? RD_LAT0 : RD_LAT1) == 1) begin
          reg_rdata_v[g] <= mem[g][reg_addr_v[g][4:2]];
        end else begin
          rd_val[g]      <= mem[g][reg_addr_v[g][4:2]];
          rd_cnt[g]      <= (g == 0 ? RD_LAT0 : RD_LAT1) - 1;
          reg_rdata_v[g] <= 32'hDEAD_BEEF;
        end
      end else if (rd_cnt[g] > 1) begin
        rd_cnt[g] <= rd_cnt[g] - 1;
      end else if (rd_cnt[g] == 1) begin
        rd_cnt[g]      <= 0;
        reg_rdata_v[g] <= rd_val[g];
      end
    end
  end

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_prdata"},    prdata_v[sel],    32'h0);
    chk({tag, "_pready"},    32'(pready_v[sel]),  32'h0);
    chk({tag, "_pslverr"},   32'(pslverr_v[sel]), 32'h0);
    chk({tag, "_reg_en"},    32'(reg_en_v[sel]),  32'h0);
    chk({tag, "_reg_we"},    32'(reg_we_v[sel]),  32'h0);
    chk({tag, "_reg_addr"},  reg_addr_v[sel],  32'h0);
    chk({tag, "_reg_wdata"}, reg_wdata_v[sel], 32'h0);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // driver: one APB transfer starting on the next cycle, observing the regfile strobe
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      output int lat, output logic err, output logic [31:0] rdat,
                      output int en_cnt, output int en_cyc, output logic en_we,
                      output logic [31:0] en_addr, output logic [31:0] en_wdata,
                      output logic [31:0] addr_at_done);
    int cyc;
    @(posedge clk); #1;
    chk("setup_pready", 32'(pready_v[sel]), 32'h0);
    chk("setup_prdata", prdata_v[sel], 32'h0);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    lat = 0; err = 1'b0; rdat = '0; en_cnt = 0; en_cyc = 0; en_we = 1'b0;
    en_addr = '0; en_wdata = '0; addr_at_done = '0; cyc = 0;
    while (lat == 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      penable = 1'b1;
      if (reg_en_v[sel]) begin
        en_cnt++;
        en_cyc   = cyc;
        en_we    = reg_we_v[sel];
        en_addr  = reg_addr_v[sel];
        en_wdata = reg_wdata_v[sel];
      end
      if (pready_v[sel]) begin
        lat          = cyc;
        err          = pslverr_v[sel];
        rdat         = prdata_v[sel];
        addr_at_done = reg_addr_v[sel];
      end else begin
        chk("wait_prdata", prdata_v[sel], 32'h0);
        chk("wait_pslverr", 32'(pslverr_v[sel]), 32'h0);
      end
    end
  endtask

  // reference model: response, latency and read data from the address map rules
  task automatic run(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic        bad;
    int          exp_lat;
    logic [31:0] exp_rd;
    int          lat, en_cnt, en_cyc;
    logic        err, en_we;
    logic [31:0] rdat, en_addr, en_wdata, addr_at_done;
    bad     = (addr % 4 != 0) || (addr > ADDR_HI);
    exp_lat = bad ? 1 : 2 + (wr ? (sel == 0 ? WR_LAT0 : WR_LAT1) : (sel == 0 ? RD_LAT0 : RD_LAT1));
    exp_rd  = (bad || wr) ? 32'h0 : ref_mem[sel][addr / 4];
    exp_q.push_back(exp_rd);
    xfer(wr, addr, data, lat, err, rdat, en_cnt, en_cyc, en_we, en_addr, en_wdata, addr_at_done);
    chk("pready_latency", 32'(lat), 32'(exp_lat));
    chk("pslverr", 32'(err), 32'(bad));
    chk("prdata", rdat, exp_q.pop_front());
    chk("reg_en_count", 32'(en_cnt), bad ? 32'h0 : 32'h1);
    if (!bad) begin
      chk("reg_en_cycle", 32'(en_cyc), 32'h1);
      chk("reg_we", 32'(en_we), 32'(wr));
      chk("reg_addr", en_addr, addr);
      chk("reg_addr_done", addr_at_done, addr);
      if (wr) begin
        chk("reg_wdata", en_wdata, data);
        ref_mem[sel][addr / 4] = data;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic        w;
    for (int g = 0; g < 2; g++) begin
      ref_mem[g][0] = '0;
      ref_mem[g][1] = '0;
    end

    // reset state
    #1;
    for (int g = 0; g < 2; g++) begin
      sel = g;
      chk_all_zero("reset");
    end
    sel = 0;
    #11 reset_n = 1'b1;

    // directed: bridge with unit latencies
    run(1'b1, 32'h0, 32'h1234_5678);
    go_idle();
    run(1'b1, 32'h0, 32'hA5A5_0F0F);
    go_idle();
    run(1'b0, 32'h0, 32'h0);
    go_idle();
    run(1'b0, 32'h2, 32'h0);
    go_idle();
    run(1'b0, 32'h8, 32'h0);
    go_idle();
    run(1'b1, 32'h4, 32'h0BAD_F00D);
    run(1'b0, 32'h4, 32'h0);
    go_idle();

    // same back-to-back pattern on the longer-latency bridge
    sel = 1;
    run(1'b1, 32'h4, 32'h7777_1111);
    run(1'b0, 32'h4, 32'h0);
    run(1'b0, 32'hC, 32'h0);
    run(1'b1, 32'h1, 32'h0);
    go_idle();
    sel = 0;

    // psel dropped while a write waits: no response, write still commits
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("abort_reg_en", 32'(reg_en_v[0]), 32'h1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_pready", 32'(pready_v[0]), 32'h0);
      chk("abort_no_reg_en", 32'(reg_en_v[0]), 32'h0);
    end
    ref_mem[0][0] = 32'hCAFE_0001;
    run(1'b0, 32'h0, 32'h0);
    go_idle();

    // asynchronous reset in the middle of a read
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4; pwdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    #1;
    reset_n = 1'b1;
    psel = 1'b0; penable = 1'b0;
    run(1'b0, 32'h4, 32'h0);
    go_idle();

    // random transfers against the reference model
    for (int i = 0; i < 60; i++) begin
      sel = (i < 35) ? 0 : 1;
      case ($urandom_range(0, 5))
        0, 1:    a = 32'h0;
        2, 3:    a = 32'h4;
        4:       a = 32'($urandom_range(0, 31));
        default: a = 32'hFFFF_FFFC;
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      run(w, a, d);
      if ($urandom_range(0, 2) == 0) go_idle();
    end
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
